// File: rtl/usr_serial_sequencer.sv
// Word-to-serial sequencer that drives an external universal shift register.
// Optional USR rotate (loopback) mode: define USR_SEQ_LOOPBACK_EN.
module usr_serial_sequencer #(
  parameter int   WIDTH = 8,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_msb_first,
  output logic             s_ready,
  output logic [1:0]       usr_ctrl,
  output logic [WIDTH-1:0] usr_din,
  output logic             usr_sil,
  output logic             usr_sir,
  input  logic [WIDTH-1:0] usr_q,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic [WIDTH-1:0] word;
  logic             dir;
  logic             accept;

  assign accept  = (state == IDLE) && s_valid;
  assign usr_din = word;

`ifdef USR_SEQ_LOOPBACK_EN
  // Rotate: the bit leaving one end re-enters at the other.
  assign usr_sir = usr_q[0];
  assign usr_sil = usr_q[WIDTH-1];
`else
  assign usr_sir = FILL;
  assign usr_sil = FILL;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      word  <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        word <= s_data;
        dir  <= s_msb_first;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    s_ready   = 1'b0;
    usr_ctrl  = 2'b00;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_nx = LOAD;
      end
      LOAD: begin
        usr_ctrl = 2'b11;
        cnt_nx   = '0;
        state_nx = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = dir ? usr_q[WIDTH-1] : usr_q[0];
        if (ser_ready) begin
          usr_ctrl = dir ? 2'b10 : 2'b01;
          // Hold the counter on the final beat so it never wraps.
          if (cnt == LAST) begin
            state_nx = DONE;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_usr_serial_sequencer.sv
// Directed bench for usr_serial_sequencer with a behavioural USR model.
module tb_usr_serial_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_msb_first;
  logic       s_ready;
  logic [1:0] usr_ctrl;
  logic [7:0] usr_din;
  logic       usr_sil;
  logic       usr_sir;
  logic [7:0] usr_q = 8'h00;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_ready;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  usr_serial_sequencer #(
    .WIDTH(8),
    .FILL (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_msb_first(s_msb_first),
    .s_ready    (s_ready),
    .usr_ctrl   (usr_ctrl),
    .usr_din    (usr_din),
    .usr_sil    (usr_sil),
    .usr_sir    (usr_sir),
    .usr_q      (usr_q),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  // External USR
  always @(posedge clk) begin
    case (usr_ctrl)
      2'b01:   usr_q <= {usr_sir, usr_q[7:1]};
      2'b10:   usr_q <= {usr_q[6:0], usr_sil};
      2'b11:   usr_q <= usr_din;
      default: usr_q <= usr_q;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // seq[i] is the i-th bit expected on ser_out; the last arg is the
  // expected USR content after DONE. Ends after the DONE cycle check.
  task automatic run_frame(input string tag, input logic [7:0] data,
                           input logic msb, input logic [7:0] seq,
                           input int stall_at, input int stall_len,
                           input logic hold, input logic [7:0] q_end);
    @(negedge clk);
    s_valid = 1'b1;
    s_data = data;
    s_msb_first = msb;
    ser_ready = 1'b1;
    #1;
    chk({tag, " idle s_ready"}, s_ready, 1);
    chk({tag, " idle ctrl"}, usr_ctrl, 2'b00);
    @(negedge clk);
    s_valid = hold;
    s_data = ~data;
    s_msb_first = ~msb;
    #1;
    chk({tag, " load ctrl"}, usr_ctrl, 2'b11);
    chk({tag, " load din"}, usr_din, data);
    chk({tag, " load s_ready"}, s_ready, 0);
    chk({tag, " load ser_valid"}, ser_valid, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          ser_ready = 1'b0;
          #1;
          chk($sformatf("%s stall%0d ctrl", tag, k), usr_ctrl, 2'b00);
          chk($sformatf("%s stall%0d bit", tag, k), ser_out, seq[i]);
          chk($sformatf("%s stall%0d done", tag, k), done, 0);
        end
      end
      @(negedge clk);
      ser_ready = 1'b1;
      #1;
      chk($sformatf("%s bit%0d", tag, i), ser_out, seq[i]);
      chk($sformatf("%s bit%0d valid", tag, i), ser_valid, 1);
      chk($sformatf("%s bit%0d ctrl", tag, i), usr_ctrl,
          msb ? 2'b10 : 2'b01);
      chk($sformatf("%s bit%0d din", tag, i), usr_din, data);
      chk($sformatf("%s bit%0d done", tag, i), done, 0);
    end
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk({tag, " done pulse"}, done, 1);
    chk({tag, " done ctrl"}, usr_ctrl, 2'b00);
    chk({tag, " done ser_valid"}, ser_valid, 0);
    chk({tag, " done s_ready"}, s_ready, 0);
    chk({tag, " usr_q end"}, usr_q, q_end);
  endtask

  initial begin
    logic [7:0] q_b4;
    logic [7:0] q_0f;
    logic [7:0] q_5a;
`ifdef USR_SEQ_LOOPBACK_EN
    q_b4 = 8'hB4;
    q_0f = 8'h0F;
    q_5a = 8'h5A;
`else
    q_b4 = 8'h00;
    q_0f = 8'h00;
    q_5a = 8'h00;
`endif
    rst = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    s_msb_first = 1'b0;
    ser_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst s_ready", s_ready, 1);
    chk("rst ctrl", usr_ctrl, 2'b00);
    chk("rst ser_valid", ser_valid, 0);
    chk("rst ser_out", ser_out, 0);
    chk("rst done", done, 0);
    chk("rst din", usr_din, 8'h00);
`ifndef USR_SEQ_LOOPBACK_EN
    chk("rst sil", usr_sil, 0);
    chk("rst sir", usr_sir, 0);
`endif
    rst = 1'b1;

    // 0xB4 LSB-first: 0,0,1,0,1,1,0,1
    run_frame("lsb", 8'hB4, 1'b0, 8'b1011_0100, -1, 0, 1'b0, q_b4);
    // 0xB4 MSB-first: 1,0,1,1,0,1,0,0
    run_frame("msb", 8'hB4, 1'b1, 8'b0010_1101, -1, 0, 1'b0, q_b4);
    @(negedge clk);
    #1;
    chk("post msb s_ready", s_ready, 1);
    chk("post msb done", done, 0);

    // 3-cycle stall after the 2nd bit
    run_frame("stall", 8'hB4, 1'b0, 8'b1011_0100, 2, 3, 1'b0, q_b4);

    // Reset in the 4th SHIFT cycle
    @(negedge clk);
    s_valid = 1'b1;
    s_data = 8'hA5;
    s_msb_first = 1'b0;
    ser_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    #1;
    chk("rstmid shifting", ser_valid, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid s_ready", s_ready, 1);
    chk("rstmid ser_valid", ser_valid, 0);
    chk("rstmid done", done, 0);
    chk("rstmid ctrl", usr_ctrl, 2'b00);
    chk("rstmid din", usr_din, 8'h00);
    @(negedge clk);
    #1;
    chk("rstmid no done", done, 0);
    // 0x0F LSB-first: 1,1,1,1,0,0,0,0
    run_frame("after rst", 8'h0F, 1'b0, 8'b0000_1111, -1, 0, 1'b0, q_0f);

    // Back-to-back with s_valid held high; 0x5A LSB-first: 0,1,0,1,1,0,1,0
    run_frame("b2b1", 8'hB4, 1'b0, 8'b1011_0100, -1, 0, 1'b1, q_b4);
    run_frame("b2b2", 8'h5A, 1'b0, 8'b0101_1010, -1, 0, 1'b0, q_5a);
    @(negedge clk);
    #1;
    chk("final s_ready", s_ready, 1);
    chk("final done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
